// File: rtl/life_cell_tick_rx_if.sv
// Tick bus from timer_8tick into a life cell.
// master drives ena/next_tick/neighbors; slave receives them.
interface life_cell_tick_rx_if;
   logic       ena;
   logic [2:0] next_tick;
   logic [7:0] neighbors;

   modport master (
      output ena,
      output next_tick,
      output neighbors
   );

   modport slave (
      input ena,
      input next_tick,
      input neighbors
   );
endinterface

// File: rtl/life_cell_tick_rx.sv
// Game of Life cell: counts live neighbours over ticks 0..7, updates on 7.
// Ports: clk, rst (sync high), tick_bus (slave), load/load_value, alive, gen_done, sync_error.
module life_cell_tick_rx #(
   parameter logic       RESET_STATE  = 1'b0,
   parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
   input  logic                      clk,
   input  logic                      rst,
   life_cell_tick_rx_if.slave        tick_bus,
   input  logic                      load,
   input  logic                      load_value,
   output logic                      alive,
   output logic                      gen_done,
   output logic                      sync_error
);

   typedef enum logic {SYNC, ACCUM} state_t;

   state_t     state, state_n;
   logic [3:0] count, count_n;
   logic [2:0] expected, expected_n;
   logic       alive_n, gen_done_n, sync_error_n;
   logic [3:0] final_cnt;
   logic       nb_bit;

   assign nb_bit    = tick_bus.neighbors[tick_bus.next_tick];
   assign final_cnt = count + {3'b000, tick_bus.neighbors[7]};

   always_comb begin
      state_n      = state;
      count_n      = count;
      expected_n   = expected;
      alive_n      = alive;
      gen_done_n   = 1'b0;
      sync_error_n = 1'b0;
      if (load) begin
         alive_n    = load_value;
         state_n    = SYNC;
         count_n    = 4'd0;
         expected_n = 3'd0;
      end else if (tick_bus.ena) begin
         unique case (state)
            SYNC: begin
               if (tick_bus.next_tick == 3'd0) begin
                  count_n    = {3'b000, tick_bus.neighbors[0]};
                  expected_n = 3'd1;
                  state_n    = ACCUM;
               end
            end
            ACCUM: begin
               if (tick_bus.next_tick == expected) begin
                  if (expected == 3'd7) begin
                     alive_n    = alive ? SURVIVE_MASK[final_cnt]
                                        : BIRTH_MASK[final_cnt];
                     gen_done_n = 1'b1;
                     count_n    = 4'd0;
                     expected_n = 3'd0;
                  end else begin
                     count_n    = count + {3'b000, nb_bit};
                     expected_n = expected + 3'd1;
                  end
               end else begin
                  // Out-of-order tick: drop the partial frame.
                  // A tick 0 is itself a valid frame start.
                  sync_error_n = 1'b1;
                  if (tick_bus.next_tick == 3'd0) begin
                     count_n    = {3'b000, tick_bus.neighbors[0]};
                     expected_n = 3'd1;
                  end else begin
                     count_n    = 4'd0;
                     expected_n = 3'd0;
                     state_n    = SYNC;
                  end
               end
            end
            default: state_n = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SYNC;
         count      <= 4'd0;
         expected   <= 3'd0;
         alive      <= RESET_STATE;
         gen_done   <= 1'b0;
         sync_error <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         expected   <= expected_n;
         alive      <= alive_n;
         gen_done   <= gen_done_n;
         sync_error <= sync_error_n;
      end
   end

endmodule
